// File: rtl/seq_detect_prog.sv
// Runtime-programmable serial pattern detector with overlap control and a
// saturating match counter. Out of reset it detects 1011 in non-overlapping mode.
module seq_detect_prog #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 16,
  parameter int LEN_W   = $clog2(MAX_LEN+1)
) (
  input  logic               clk_i,
  input  logic               reset_ni,
  input  logic               cfg_we_i,
  input  logic [MAX_LEN-1:0] cfg_pattern_i,
  input  logic [LEN_W-1:0]   cfg_len_i,
  input  logic               cfg_overlap_i,
  output logic               cfg_err_o,
  input  logic               inp_valid_i,
  input  logic               inp_bit_i,
  input  logic               clr_count_i,
  output logic               seq_seen_o,
  output logic [CNT_W-1:0]   match_count_o,
  output logic               count_sat_o
);

  localparam logic [LEN_W-1:0]   FULL    = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0]   RST_LEN = LEN_W'(4);
  localparam logic [MAX_LEN-1:0] RST_PAT = MAX_LEN'(4'b1011);
  localparam logic [CNT_W-1:0]   CNT_MAX = '1;

  logic [MAX_LEN-1:0] pat_q, pat_d, hist_q, hist_d, hist_nx;
  logic [LEN_W-1:0]   len_q, len_d, fill_q, fill_d, fill_nx;
  logic               ovl_q, ovl_d, seen_q, seen_d, err_q, err_d, sat_q, sat_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_base;
  logic [MAX_LEN-1:0] bit_ok;
  logic               cfg_ok, accept, match;

  // A legal write owns the cycle; a rejected one lets the data bit through.
  assign cfg_ok  = cfg_we_i && (cfg_len_i != '0) && (cfg_len_i <= FULL);
  assign accept  = inp_valid_i && !cfg_ok;
  assign hist_nx = accept ? {hist_q[MAX_LEN-2:0], inp_bit_i} : hist_q;
  assign fill_nx = (accept && (fill_q != FULL)) ? fill_q + LEN_W'(1) : fill_q;

  // Positions at or above len are don't-care.
  for (genvar i = 0; i < MAX_LEN; i++) begin : g_cmp
    assign bit_ok[i] = (LEN_W'(i) >= len_q) || (hist_nx[i] == pat_q[i]);
  end

  assign match = accept && (fill_nx >= len_q) && (&bit_ok);

  always_comb begin
    pat_d  = pat_q;
    len_d  = len_q;
    ovl_d  = ovl_q;
    hist_d = hist_nx;
    fill_d = (match && !ovl_q) ? '0 : fill_nx;
    seen_d = match;
    err_d  = cfg_we_i && !cfg_ok;
    if (cfg_ok) begin
      pat_d  = cfg_pattern_i;
      len_d  = cfg_len_i;
      ovl_d  = cfg_overlap_i;
      hist_d = '0;
      fill_d = '0;
    end
    // Clear first, then count, so clear+match lands on 1.
    cnt_base = clr_count_i ? '0 : cnt_q;
    cnt_d    = (match && (cnt_base != CNT_MAX)) ? cnt_base + CNT_W'(1) : cnt_base;
    sat_d    = (cnt_d == CNT_MAX);
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      pat_q  <= RST_PAT;
      len_q  <= RST_LEN;
      ovl_q  <= 1'b0;
      hist_q <= '0;
      fill_q <= '0;
      seen_q <= 1'b0;
      err_q  <= 1'b0;
      cnt_q  <= '0;
      sat_q  <= 1'b0;
    end else begin
      pat_q  <= pat_d;
      len_q  <= len_d;
      ovl_q  <= ovl_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      seen_q <= seen_d;
      err_q  <= err_d;
      cnt_q  <= cnt_d;
      sat_q  <= sat_d;
    end
  end

  assign seq_seen_o    = seen_q;
  assign cfg_err_o     = err_q;
  assign match_count_o = cnt_q;
  assign count_sat_o   = sat_q;

endmodule
